// File: rtl/dadda_mac_acc.sv
// Burst accumulator behind an 8x8 Dadda multiplier: sums len unsigned 16-bit
// products into an ACC_W-bit register with a sticky carry-out flag.
//
// Handshakes: a product transfers on a cycle where prod_valid && prod_ready;
// the result transfers on a cycle where acc_valid && acc_ready. The block
// never drops either valid/ready once asserted until the matching transfer.
module dadda_mac_acc #(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       len,
    input  logic [15:0]      prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [ACC_W-1:0] acc;
    logic [4:0]       cnt;
    logic [4:0]       len_q;
    logic             ovf_q;
    logic             load;
    logic             take;
    logic             last;
    logic [ACC_W:0]   sum;

    // One extra bit on the adder captures the carry out of the accumulator.
    assign sum  = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, prod};
    assign last = (cnt + 5'd1) == len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        prod_ready = 1'b0;
        acc_valid  = 1'b0;
        busy       = 1'b0;
        load       = 1'b0;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = ACC;
                end
            end
            ACC: begin
                prod_ready = 1'b1;
                busy       = 1'b1;
                if (prod_valid) begin
                    take = 1'b1;
                    if (last) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                acc_valid = 1'b1;
                busy      = 1'b1;
                // A start arriving together with acc_ready is not queued.
                if (acc_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else if (load) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
            len_q <= (len == 4'd0) ? 5'd16 : {1'b0, len};
        end else if (take) begin
            acc   <= sum[ACC_W-1:0];
            ovf_q <= ovf_q | sum[ACC_W];
            cnt   <= cnt + 5'd1;
        end
    end

    assign acc_out = acc;
    assign ovf     = ovf_q;

endmodule

// File: doc/dadda_mac_acc.md
DADDA_MAC_ACC -- requirements
Module: dadda_mac_acc

Interface
REQ-001 Parameter ACC_W, default 20: accumulator width in bits; legal values 16..32.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: begins a burst; sampled only in IDLE.
REQ-005 Port len, input, 4 bits: number of products in the burst; 0 encodes 16; sampled with start.
REQ-006 Port prod, input, 16 bits: unsigned product from the upstream 8x8 Dadda multiplier.
REQ-007 Port prod_valid, input, 1 bit: prod is valid this cycle.
REQ-008 Port prod_ready, output, 1 bit: block accepts prod this cycle.
REQ-009 Port acc_out, output, ACC_W bits: accumulated sum.
REQ-010 Port acc_valid, output, 1 bit: acc_out holds the final burst sum.
REQ-011 Port acc_ready, input, 1 bit: the consumer takes acc_out.
REQ-012 Port ovf, output, 1 bit: sticky flag; a carry out of ACC_W occurred during the burst.
REQ-013 Port busy, output, 1 bit: high in ACC and DONE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-015 IDLE: prod_ready=0, acc_valid=0; on start=1, latch the term count (len, with 0 as 16), clear the accumulator, ovf and the term counter, then go to ACC.
REQ-016 ACC: prod_ready=1; a transfer occurs when prod_valid and prod_ready are both high in the same cycle.
REQ-017 Each transfer SHALL update the accumulator as acc <= (acc + zero-extended prod) mod 2^ACC_W, and increment the term counter.
REQ-018 ovf SHALL be set on any transfer whose addition carries out of bit ACC_W-1, and remain set until the next start or reset.
REQ-019 Cycles in ACC with prod_valid=0 SHALL leave the accumulator and counter unchanged, with no timeout.
REQ-020 The transfer of the final term SHALL move the FSM to DONE; acc_valid=1 and acc_out include that term in the next cycle (1-cycle latency).
REQ-021 In ACC, prod_ready SHALL be high in the final-term cycle and low from the following cycle.
REQ-022 DONE: acc_valid=1, and acc_out and ovf SHALL stay stable until acc_ready=1.
REQ-023 In DONE, acc_valid=1 with acc_ready=1 SHALL return the FSM to IDLE; acc_valid=0 in the next cycle; acc_out keeps its value.
REQ-024 start SHALL be ignored in ACC and DONE, and in IDLE unless the FSM is in IDLE during that cycle; no burst is queued.
REQ-025 When start and acc_ready are high in the same DONE cycle, the FSM SHALL only return to IDLE; the new burst requires start in a later cycle.
REQ-026 acc_out SHALL be the registered accumulator value in every state, with no combinational path from prod to acc_out.
REQ-027 busy SHALL be decoded from the state register: 1 in ACC and DONE, 0 in IDLE.

Reset
REQ-028 While rst=1, the FSM SHALL be IDLE, and acc_out, the term counter, the latched len, ovf, acc_valid, prod_ready and busy SHALL all be 0, independent of clk.
REQ-029 Asserting rst mid-burst (ACC or DONE) SHALL discard all partial state; operation restarts only on start after rst deasserts.

Verification
REQ-030 The bench SHALL cover: len=1, start, prod=0xFE01 valid -> one cycle later acc_valid=1, acc_out=65025, ovf=0.
REQ-031 The bench SHALL cover: len=0, 16 back-to-back transfers of 0xFE01 -> acc_out=1040400 (0xFE010), ovf=0; prod_ready low after the 16th transfer.
REQ-032 The bench SHALL cover: len=3, products 6, 7 and 8 with 2 idle cycles between transfers -> acc_out=21; no count advance on idle cycles.
REQ-033 The bench SHALL cover: DONE with acc_ready=0 for 5 cycles and start pulsed -> acc_out stable, start ignored; acc_ready=1 -> IDLE next cycle.
REQ-034 The bench SHALL cover: len=4, rst pulsed after 2 transfers -> all outputs 0 and IDLE immediately; a new start with len=1, prod=5 -> acc_out=5.
REQ-035 The bench SHALL cover: ACC_W=16, len=2, 0xFE01 twice -> acc_out=0xFC02, ovf=1; the next start clears ovf.
